mul_pipeline: RTL and testbench

Pipelined RV32M multiply unit in the execute stage. It consumes the decode/execute register outputs and produces a ROB-tagged 32-bit result a fixed number of cycles later. The unit accepts one multiply per cycle and supports back-pressure from the writeback/ROB port, collapsing bubbles between its internal stages. It also supports a synchronous flush for mispredict recovery.

---
 rtl/mul_pipeline_pkg.sv | 18 +
 rtl/mul_stage_reg.sv | 41 ++++
 rtl/mul_pipeline.sv | 108 ++++++++++
 tb/tb_mul_pipeline.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pipeline_pkg.sv
// Shared constants for the RV32M multiply pipeline: instruction-type code,
// funct3 encodings and default sizing.
package mul_pipeline_pkg;

    localparam int unsigned MUL_WORD_SIZE       = 32;
    localparam int unsigned MUL_INSTR_TYPE_SZ   = 4;
    localparam int unsigned MUL_ROB_ENTRY_WIDTH = 6;
    localparam int unsigned MUL_LATENCY_DEF     = 5;
    localparam int unsigned INSTR_TYPE_MUL      = 3;

    typedef enum logic [2:0] {
        F3_MUL    = 3'd0,
        F3_MULH   = 3'd1,
        F3_MULHSU = 3'd2,
        F3_MULHU  = 3'd3
    } mul_op_e;

endpackage

// File: rtl/mul_stage_reg.sv
// One pipeline stage: valid bit plus funct3/tag/data payload, loaded when the
// stage advances and cleared by flush or reset.
module mul_stage_reg #(
    parameter int unsigned DATA_W = 66,
    parameter int unsigned TAG_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              load,
    input  logic              valid_in,
    input  logic [2:0]        funct3_in,
    input  logic [TAG_W-1:0]  tag_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              valid,
    output logic [2:0]        funct3,
    output logic [TAG_W-1:0]  tag,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid  <= 1'b0;
            funct3 <= '0;
            tag    <= '0;
            data   <= '0;
        end else begin
            if (flush)
                valid <= 1'b0;
            else if (load)
                valid <= valid_in;
            // Payload only moves with a live operation; bubbles leave it untouched.
            if (load && valid_in) begin
                funct3 <= funct3_in;
                tag    <= tag_in;
                data   <= data_in;
            end
        end
    end

endmodule

// File: rtl/mul_pipeline.sv
// Pipelined RV32M multiply unit: stage 1 holds extended operands, stage 2 the
// 66-bit product, the last stage the selected result word; bubbles compress.
module mul_pipeline
    import mul_pipeline_pkg::*;
#(
    parameter int unsigned WORD_SIZE       = MUL_WORD_SIZE,
    parameter int unsigned INSTR_TYPE_SZ   = MUL_INSTR_TYPE_SZ,
    parameter int unsigned ROB_ENTRY_WIDTH = MUL_ROB_ENTRY_WIDTH,
    parameter int unsigned MUL_LATENCY     = MUL_LATENCY_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       valid,
    input  logic [INSTR_TYPE_SZ-1:0]   instruction_type,
    input  logic [2:0]                 funct3,
    input  logic [WORD_SIZE-1:0]       s1,
    input  logic [WORD_SIZE-1:0]       s2,
    input  logic [ROB_ENTRY_WIDTH-1:0] rob_id,
    input  logic                       stall,
    input  logic                       flush,
    output logic                       stall_out,
    output logic [WORD_SIZE-1:0]       result,
    output logic [ROB_ENTRY_WIDTH-1:0] rob_id_out,
    output logic                       valid_out
);

    localparam int unsigned OP_W = WORD_SIZE + 1;
    localparam int unsigned DW   = 2 * OP_W;
    localparam int unsigned L    = MUL_LATENCY;

    // Index 0 is the D/E input side; 1..L are the registered stages.
    logic                       v   [L+1];
    logic [2:0]                 f3  [L+1];
    logic [ROB_ENTRY_WIDTH-1:0] tag [L+1];
    logic [DW-1:0]              d   [L+1];
    logic [L+1:1]               adv;
    logic                       take;
    logic                       rs1_signed;
    logic                       rs2_signed;
    logic                       unused_ok;

    function automatic logic [DW-1:0] mul_ext(input logic [DW-1:0] ops);
        logic [DW-1:0] pa;
        logic [DW-1:0] pb;
        pa = {{OP_W{ops[DW-1]}}, ops[DW-1:OP_W]};
        pb = {{OP_W{ops[OP_W-1]}}, ops[OP_W-1:0]};
        return pa * pb;
    endfunction

    function automatic logic [WORD_SIZE-1:0] pick(input logic [2*WORD_SIZE-1:0] p,
                                                  input logic [2:0] op);
        return (op == F3_MUL) ? p[WORD_SIZE-1:0] : p[2*WORD_SIZE-1:WORD_SIZE];
    endfunction

    always_comb begin
        adv      = '0;
        adv[L+1] = !stall;
        for (int unsigned k = L; k >= 1; k--)
            adv[k] = !v[k] || adv[k+1];
    end

    assign take       = valid && (instruction_type == INSTR_TYPE_SZ'(INSTR_TYPE_MUL)) && adv[1];
    assign rs1_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU);
    assign rs2_signed = (funct3 == F3_MULH);

    assign v[0]   = take;
    assign f3[0]  = funct3;
    assign tag[0] = rob_id;
    assign d[0]   = {rs1_signed & s1[WORD_SIZE-1], s1, rs2_signed & s2[WORD_SIZE-1], s2};

    for (genvar k = 1; k <= L; k++) begin : g_stage
        logic [DW-1:0] nxt;

        always_comb begin
            nxt = d[k-1];
            if (k == 2)
                nxt = mul_ext(d[k-1]);
            if (k == L)
                nxt = DW'(pick(nxt[2*WORD_SIZE-1:0], f3[k-1]));
        end

        mul_stage_reg #(
            .DATA_W (DW),
            .TAG_W  (ROB_ENTRY_WIDTH)
        ) u_reg (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .load      (adv[k]),
            .valid_in  (v[k-1]),
            .funct3_in (f3[k-1]),
            .tag_in    (tag[k-1]),
            .data_in   (nxt),
            .valid     (v[k]),
            .funct3    (f3[k]),
            .tag       (tag[k]),
            .data      (d[k])
        );
    end

    assign valid_out  = v[L];
    assign result     = d[L][WORD_SIZE-1:0];
    assign rob_id_out = tag[L];
    assign stall_out  = v[1] && !adv[1];

    assign unused_ok = ^{d[L][DW-1:WORD_SIZE], f3[L]};

endmodule

// File: tb/tb_mul_pipeline.sv
// Scoreboard bench for mul_pipeline: driver pushes hand-computed results on
// acceptance, an independent monitor pops and compares on each output transfer.
module tb_mul_pipeline;
    import mul_pipeline_pkg::*;

    localparam int unsigned W  = 32;
    localparam int unsigned TW = 4;
    localparam int unsigned RW = 6;
    localparam int unsigned L  = 5;
    localparam logic [TW-1:0] T_MUL = TW'(INSTR_TYPE_MUL);
    localparam logic [TW-1:0] T_ALU = 4'd0;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          valid = 1'b0;
    logic [TW-1:0] instruction_type = '0;
    logic [2:0]    funct3 = '0;
    logic [W-1:0]  s1 = '0;
    logic [W-1:0]  s2 = '0;
    logic [RW-1:0] rob_id = '0;
    logic          stall = 1'b0;
    logic          flush = 1'b0;
    logic          stall_out;
    logic [W-1:0]  result;
    logic [RW-1:0] rob_id_out;
    logic          valid_out;

    always #5 clk = ~clk;

    mul_pipeline #(
        .WORD_SIZE       (W),
        .INSTR_TYPE_SZ   (TW),
        .ROB_ENTRY_WIDTH (RW),
        .MUL_LATENCY     (L)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .valid            (valid),
        .instruction_type (instruction_type),
        .funct3           (funct3),
        .s1               (s1),
        .s2               (s2),
        .rob_id           (rob_id),
        .stall            (stall),
        .flush            (flush),
        .stall_out        (stall_out),
        .result           (result),
        .rob_id_out       (rob_id_out),
        .valid_out        (valid_out)
    );

    typedef struct packed {
        logic [RW-1:0] rob;
        logic [W-1:0]  res;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Directed operand vectors with hand-computed results.
    localparam int NV = 9;
    localparam logic [2:0]  V_F [NV] = '{3'd1, 3'd3, 3'd2, 3'd0, 3'd1, 3'd3, 3'd0, 3'd2, 3'd1};
    localparam logic [31:0] V_A [NV] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                         32'h80000000, 32'h80000000, 32'h12345678, 32'h7FFFFFFF,
                                         32'hFFFFFFFE};
    localparam logic [31:0] V_B [NV] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                         32'h80000000, 32'h00000002, 32'h00000010, 32'hFFFFFFFF,
                                         32'h00000003};
    localparam logic [31:0] V_R [NV] = '{32'h00000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000001,
                                         32'h40000000, 32'h00000001, 32'h23456780, 32'h7FFFFFFE,
                                         32'hFFFFFFFF};
    localparam logic [31:0] B2B [8] = '{32'd0, 32'd2, 32'd6, 32'd12, 32'd20, 32'd30, 32'd42, 32'd56};
    localparam logic [31:0] ST  [8] = '{32'd300, 32'd303, 32'd306, 32'd309,
                                        32'd312, 32'd315, 32'd318, 32'd321};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [RW-1:0] rob, input logic [31:0] exp);
        int unsigned tries = 0;
        forever begin
            @(negedge clk);
            valid = 1'b1; instruction_type = T_MUL; funct3 = f;
            s1 = a; s2 = b; rob_id = rob;
            #1;
            if (!stall_out) begin
                sb.push_back({rob, exp});
                @(posedge clk);
                return;
            end
            tries++;
            if (tries > 100) begin
                checks++; failures++;
                $display("FAIL issue_timeout: rob %0d never accepted, expected acceptance", rob);
                return;
            end
        end
    endtask

    task automatic idle();
        @(negedge clk);
        valid = 1'b0;
        instruction_type = T_ALU;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 80) begin
            @(negedge clk); #3;
            n++;
        end
        check(name, 32'(sb.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic expect_idle(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk); #3;
            check(name, 32'(valid_out), 32'd0);
        end
    endtask

    // Monitor: a transfer happens on the next edge when valid_out && !stall.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk); #2;
            if (!reset && valid_out && !stall) begin
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_output: got rob %0d result 0x%08h expected no output",
                             rob_id_out, result);
                end else begin
                    e = sb.pop_front();
                    check("result", result, e.res);
                    check("rob_id_out", 32'(rob_id_out), 32'(e.rob));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int lat;
        int run, first, last;
        int accepted, idx;
        logic [31:0] held_res;
        logic [RW-1:0] held_rob;

        // Reset values
        repeat (2) @(negedge clk);
        #3;
        check("reset_valid_out", 32'(valid_out), 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_rob_id_out", 32'(rob_id_out), 32'd0);
        check("reset_stall_out", 32'(stall_out), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single MUL and its latency
        issue(3'd0, 32'd7, 32'd6, 6'd3, 32'h0000002A);
        idle();
        #3;
        lat = 0;
        while (!valid_out && lat < 20) begin
            @(negedge clk); #3;
            lat++;
        end
        check("latency_edges", 32'(lat), 32'(L - 1));
        wait_drain("drain_single");

        // Signedness corner vectors, back-to-back
        for (int i = 0; i < NV; i++)
            issue(V_F[i], V_A[i], V_B[i], RW'(10 + i), V_R[i]);
        idle();
        wait_drain("drain_vectors");

        // Non-multiply instruction types are ignored
        @(negedge clk);
        valid = 1'b1; instruction_type = T_ALU; funct3 = 3'd0; s1 = 32'd5; s2 = 32'd5;
        repeat (3) @(negedge clk);
        valid = 1'b0;
        expect_idle("foreign_type_ignored", L + 2);

        // Eight back-to-back MULs: eight consecutive outputs
        run = 0; first = -1; last = -1;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    issue(3'd0, 32'(i), 32'(i + 1), RW'(20 + i), B2B[i]);
                idle();
            end
            begin
                for (int c = 0; c < 30; c++) begin
                    @(negedge clk); #3;
                    if (valid_out) begin
                        run++;
                        if (first < 0) first = c;
                        last = c;
                    end
                end
            end
        join
        check("b2b_count", 32'(run), 32'd8);
        check("b2b_span", 32'(last - first), 32'd7);
        wait_drain("drain_b2b");

        // Stall with continuous input: pipe fills to L, outputs hold
        @(negedge clk);
        stall = 1'b1;
        accepted = 0; idx = 0; held_res = '0; held_rob = '0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            valid = 1'b1; instruction_type = T_MUL; funct3 = 3'd0;
            s1 = 32'(100 + idx); s2 = 32'd3; rob_id = RW'(32 + idx);
            #1;
            if (!stall_out) begin
                sb.push_back({RW'(32 + idx), ST[idx]});
                idx++;
                accepted++;
            end
            if (c == 5) begin
                held_res = result;
                held_rob = rob_id_out;
                check("stall_head_result", result, ST[0]);
            end
        end
        valid = 1'b0;
        check("stall_accepted", 32'(accepted), 32'(L));
        check("stall_out_full", 32'(stall_out), 32'd1);
        check("stall_hold_result", result, held_res);
        check("stall_hold_rob", 32'(rob_id_out), 32'(held_rob));
        @(negedge clk);
        stall = 1'b0;
        for (int i = idx; i < 8; i++)
            issue(3'd0, 32'(100 + i), 32'd3, RW'(32 + i), ST[i]);
        idle();
        wait_drain("drain_stall");

        // Flush with three in flight, coinciding with stall
        @(negedge clk);
        stall = 1'b1;
        for (int i = 0; i < 3; i++)
            issue(3'd0, 32'(i + 1), 32'd9, RW'(40 + i), 32'(9 * (i + 1)));
        idle();
        repeat (4) @(negedge clk);
        #3;
        check("flush_pre_valid", 32'(valid_out), 32'd1);
        @(negedge clk);
        flush = 1'b1;
        valid = 1'b1; instruction_type = T_MUL; funct3 = 3'd0; s1 = 32'd4; s2 = 32'd4; rob_id = 6'd45;
        sb.delete();
        @(negedge clk);
        flush = 1'b0;
        valid = 1'b0;
        #3;
        check("flush_valid_out", 32'(valid_out), 32'd0);
        expect_idle("flush_idle", L + 1);
        @(negedge clk);
        stall = 1'b0;
        issue(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd50, 32'hFFFFFFFE);
        idle();
        wait_drain("drain_flush");

        // Asynchronous reset with the pipe full
        @(negedge clk);
        stall = 1'b1;
        for (int i = 0; i < 5; i++)
            issue(3'd0, 32'(i + 2), 32'd2, RW'(56 + i), 32'(2 * (i + 2)));
        idle();
        #3;
        check("reset_pre_full", 32'(stall_out), 32'd1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_valid_out", 32'(valid_out), 32'd0);
        check("async_reset_result", result, 32'd0);
        check("async_reset_rob_id_out", 32'(rob_id_out), 32'd0);
        check("async_reset_stall_out", 32'(stall_out), 32'd0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        stall = 1'b0;
        expect_idle("post_reset_idle", L + 2);
        issue(3'd1, 32'hFFFFFFFE, 32'h00000003, 6'd61, 32'hFFFFFFFF);
        idle();
        wait_drain("drain_final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
